// File: rtl/mem_write_checker_if.sv
// ---------------------------------------------------------------------------
// mem_write_checker_if
// Bundles the table-load handshake, run control, observed core write port and
// verdict outputs of mem_write_checker.
//   slave  : the checker side (inputs: clear, load_*, start, MemWrite, DataAdr,
//            WriteData; outputs: load_ready, pass, fail, done, fail_code,
//            fail_adr, fail_data, match_count, run_cycles)
//   master : the side that drives the checker (bench / SoC glue)
// ---------------------------------------------------------------------------
interface mem_write_checker_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
);
  localparam int MC_W = $clog2(NUM_CHECKS + 1);
  localparam int RC_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              clear;
  logic              load_valid;
  logic [ADDR_W-1:0] load_adr;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              start;
  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;
  logic              pass;
  logic              fail;
  logic              done;
  logic [1:0]        fail_code;
  logic [ADDR_W-1:0] fail_adr;
  logic [DATA_W-1:0] fail_data;
  logic [MC_W-1:0]   match_count;
  logic [RC_W-1:0]   run_cycles;

  modport slave (
    input  clear, load_valid, load_adr, load_data, start,
           MemWrite, DataAdr, WriteData,
    output load_ready, pass, fail, done, fail_code, fail_adr, fail_data,
           match_count, run_cycles
  );

  modport master (
    output clear, load_valid, load_adr, load_data, start,
           MemWrite, DataAdr, WriteData,
    input  load_ready, pass, fail, done, fail_code, fail_adr, fail_data,
           match_count, run_cycles
  );
endinterface

// File: rtl/mem_write_checker.sv
// ---------------------------------------------------------------------------
// mem_write_checker
// Self-checking monitor for a core's data-memory write port. An ordered table
// of expected (address, data) writes is loaded, then after start every core
// write is compared in order against the next expected entry. Writes to a
// scratch address may be tolerated. The verdict (pass / fail with cause /
// timeout) is sticky until clear or reset, and all outputs are registered.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : mem_write_checker_if.slave (load handshake, start, clear, core
//            write port, verdict and progress outputs)
// ---------------------------------------------------------------------------
module mem_write_checker #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                NUM_CHECKS     = 4,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter int                IGNORE_EN      = 1,
  parameter logic [ADDR_W-1:0] IGNORE_ADR     = ADDR_W'(96)
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_write_checker_if.slave    bus
);
  localparam int MC_W = $clog2(NUM_CHECKS + 1);
  localparam int RC_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [MC_W-1:0]   n_r, n_s;
  logic [MC_W-1:0]   match_count_r, match_count_s;   // doubles as the table index
  logic [RC_W-1:0]   run_cycles_r, run_cycles_s;
  logic              load_ready_r, load_ready_s;
  logic              pass_r, pass_s;
  logic              fail_r, fail_s;
  logic              done_r, done_s;
  logic [1:0]        fail_code_r, fail_code_s;
  logic [ADDR_W-1:0] fail_adr_r, fail_adr_s;
  logic [DATA_W-1:0] fail_data_r, fail_data_s;
  logic              load_fire_s;

  logic [ADDR_W-1:0] exp_adr_r  [NUM_CHECKS];
  logic [DATA_W-1:0] exp_data_r [NUM_CHECKS];
  logic [ADDR_W-1:0] exp_adr_s;
  logic [DATA_W-1:0] exp_data_s;
  logic              adr_hit_s, data_hit_s, ign_hit_s;

  // Select the expected entry at the current index.
  always_comb begin
    exp_adr_s  = '0;
    exp_data_s = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      exp_adr_s  = (match_count_r == MC_W'(i)) ? exp_adr_r[i]  : exp_adr_s;
      exp_data_s = (match_count_r == MC_W'(i)) ? exp_data_r[i] : exp_data_s;
    end
  end

  // Next-state and next-output logic; clear overrides everything.
  always_comb begin
    state_s       = state_r;
    n_s           = n_r;
    match_count_s = match_count_r;
    run_cycles_s  = run_cycles_r;
    pass_s        = pass_r;
    fail_s        = fail_r;
    fail_code_s   = fail_code_r;
    fail_adr_s    = fail_adr_r;
    fail_data_s   = fail_data_r;
    load_fire_s   = 1'b0;
    // X/Z on the bus makes these compare false, which lands in the code-1 path.
    adr_hit_s     = (bus.DataAdr == exp_adr_s);
    data_hit_s    = (bus.WriteData == exp_data_s);
    ign_hit_s     = (IGNORE_EN != 0) && (bus.DataAdr == IGNORE_ADR);

    if (bus.clear) begin
      state_s       = ST_LOAD;
      n_s           = '0;
      match_count_s = '0;
      run_cycles_s  = '0;
      pass_s        = 1'b0;
      fail_s        = 1'b0;
      fail_code_s   = 2'd0;
      fail_adr_s    = '0;
      fail_data_s   = '0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          load_fire_s = bus.load_valid && (n_r < MC_W'(NUM_CHECKS));
          n_s         = n_r + MC_W'(load_fire_s);
          // start sees the count including a load in the same cycle
          if (bus.start && (n_s != '0)) begin
            state_s       = ST_RUN;
            match_count_s = '0;
            run_cycles_s  = '0;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_RUN: begin
          if (bus.MemWrite && adr_hit_s && data_hit_s) begin
            match_count_s = match_count_r + MC_W'(1);
            if (match_count_s == n_r) begin
              state_s = ST_PASS;
              pass_s  = 1'b1;
            end else begin
              state_s = ST_RUN;
            end
          end else if (bus.MemWrite && ign_hit_s) begin
            state_s = ST_RUN;
          end else if (bus.MemWrite && adr_hit_s) begin
            state_s     = ST_FAIL;
            fail_s      = 1'b1;
            fail_code_s = 2'd2;
            fail_adr_s  = bus.DataAdr;
            fail_data_s = bus.WriteData;
          end else if (bus.MemWrite) begin
            state_s     = ST_FAIL;
            fail_s      = 1'b1;
            fail_code_s = 2'd1;
            fail_adr_s  = bus.DataAdr;
            fail_data_s = bus.WriteData;
          end else begin
            state_s = ST_RUN;
          end
          // Timeout only applies when this cycle reached no verdict; the
          // counter stops on the cycle that ends the run.
          if (state_s == ST_RUN) begin
            if (run_cycles_r == RC_W'(TIMEOUT_CYCLES - 1)) begin
              state_s     = ST_FAIL;
              fail_s      = 1'b1;
              fail_code_s = 2'd3;
              fail_adr_s  = '0;
              fail_data_s = '0;
            end else begin
              run_cycles_s = run_cycles_r + RC_W'(1);
            end
          end else begin
            run_cycles_s = run_cycles_r;
          end
        end
        ST_PASS, ST_FAIL: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_LOAD;
        end
      endcase
    end

    load_ready_s = (state_s == ST_LOAD) && (n_s < MC_W'(NUM_CHECKS));
    done_s       = pass_s | fail_s;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_LOAD;
      n_r           <= '0;
      match_count_r <= '0;
      run_cycles_r  <= '0;
      load_ready_r  <= 1'b1;
      pass_r        <= 1'b0;
      fail_r        <= 1'b0;
      done_r        <= 1'b0;
      fail_code_r   <= 2'd0;
      fail_adr_r    <= '0;
      fail_data_r   <= '0;
    end else begin
      state_r       <= state_s;
      n_r           <= n_s;
      match_count_r <= match_count_s;
      run_cycles_r  <= run_cycles_s;
      load_ready_r  <= load_ready_s;
      pass_r        <= pass_s;
      fail_r        <= fail_s;
      done_r        <= done_s;
      fail_code_r   <= fail_code_s;
      fail_adr_r    <= fail_adr_s;
      fail_data_r   <= fail_data_s;
    end
  end

  // Expected-write table; contents are qualified by n_r so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (load_fire_s && (n_r == MC_W'(i))) begin
        exp_adr_r[i]  <= bus.load_adr;
        exp_data_r[i] <= bus.load_data;
      end
    end
  end

  assign bus.load_ready  = load_ready_r;
  assign bus.pass        = pass_r;
  assign bus.fail        = fail_r;
  assign bus.done        = done_r;
  assign bus.fail_code   = fail_code_r;
  assign bus.fail_adr    = fail_adr_r;
  assign bus.fail_data   = fail_data_r;
  assign bus.match_count = match_count_r;
  assign bus.run_cycles  = run_cycles_r;

endmodule

// File: tb/tb_mem_write_checker.sv
// ---------------------------------------------------------------------------
// tb_mem_write_checker
// Directed bench: one checker built with a short timeout and scratch-address
// tolerance, and a second built without tolerance that sees the same stimulus.
// ---------------------------------------------------------------------------
module tb_mem_write_checker;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(4), .TIMEOUT_CYCLES(8))    bus ();
  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(4), .TIMEOUT_CYCLES(1000)) bus_ni ();

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_CHECKS(4), .TIMEOUT_CYCLES(8),
    .IGNORE_EN(1), .IGNORE_ADR(32'd96)
  ) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_CHECKS(4), .TIMEOUT_CYCLES(1000),
    .IGNORE_EN(0), .IGNORE_ADR(32'd96)
  ) dut_ni (.clk(clk), .reset(reset), .bus(bus_ni.slave));

  assign bus_ni.clear      = bus.clear;
  assign bus_ni.load_valid = bus.load_valid;
  assign bus_ni.load_adr   = bus.load_adr;
  assign bus_ni.load_data  = bus.load_data;
  assign bus_ni.start      = bus.start;
  assign bus_ni.MemWrite   = bus.MemWrite;
  assign bus_ni.DataAdr    = bus.DataAdr;
  assign bus_ni.WriteData  = bus.WriteData;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.load_valid = 1'b1;
    bus.load_adr   = a;
    bus.load_data  = d;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = a;
    bus.WriteData = d;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.clear = 1'b0; bus.load_valid = 1'b0; bus.load_adr = 32'd0; bus.load_data = 32'd0;
    bus.start = 1'b0; bus.MemWrite = 1'b0; bus.DataAdr = 32'd0; bus.WriteData = 32'd0;
    #1 reset = 1'b0;
    #1;
    chk("rst_load_ready", bus.load_ready, 1);
    chk("rst_pass", bus.pass, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_code", bus.fail_code, 0);
    chk("rst_mc", bus.match_count, 0);
    chk("rst_rc", bus.run_cycles, 0);
    tick(); tick();
    reset = 1'b1;

    // start with an empty table is ignored
    go();
    chk("empty_start_ready", bus.load_ready, 1);
    wr(32'd5, 32'd5);
    chk("empty_start_nofail", bus.fail, 0);

    // pass with scratch writes in between
    load(32'd100, 32'd7);
    chk("t1_ready_after_load", bus.load_ready, 1);
    go();
    chk("t1_ready_run", bus.load_ready, 0);
    wr(32'd96, 32'd3);
    wr(32'd96, 32'd5);
    chk("t1_pass_early", bus.pass, 0);
    wr(32'd100, 32'd7);
    chk("t1_pass", bus.pass, 1);
    chk("t1_done", bus.done, 1);
    chk("t1_mc", bus.match_count, 1);
    chk("t1_code", bus.fail_code, 0);
    wr(32'd104, 32'd9);
    chk("t1_sticky_pass", bus.pass, 1);
    chk("t1_sticky_nofail", bus.fail, 0);
    do_clear();
    chk("clr_pass", bus.pass, 0);
    chk("clr_mc", bus.match_count, 0);
    chk("clr_ready", bus.load_ready, 1);

    // address mismatch
    load(32'd100, 32'd7);
    go();
    wr(32'd104, 32'd7);
    chk("t2_fail", bus.fail, 1);
    chk("t2_code", bus.fail_code, 1);
    chk("t2_adr", bus.fail_adr, 104);
    chk("t2_data", bus.fail_data, 7);
    wr(32'd100, 32'd7);
    chk("t2_sticky_pass", bus.pass, 0);
    chk("t2_sticky_code", bus.fail_code, 1);
    chk("t2_sticky_adr", bus.fail_adr, 104);
    do_clear();
    chk("t2_clr_code", bus.fail_code, 0);
    chk("t2_clr_adr", bus.fail_adr, 0);

    // data mismatch
    load(32'd100, 32'd7);
    go();
    wr(32'd100, 32'd6);
    chk("t3_code", bus.fail_code, 2);
    chk("t3_adr", bus.fail_adr, 100);
    chk("t3_data", bus.fail_data, 6);
    do_clear();

    // scratch write: tolerated only when enabled
    load(32'd100, 32'd7);
    go();
    wr(32'd96, 32'd1);
    chk("t3b_ign_nofail", bus.fail, 0);
    chk("t3b_noign_code", bus_ni.fail_code, 1);
    chk("t3b_noign_adr", bus_ni.fail_adr, 96);
    do_clear();

    // timeout after 8 RUN cycles
    load(32'd100, 32'd7);
    go();
    repeat (7) tick();
    chk("t4_not_yet", bus.fail, 0);
    chk("t4_rc7", bus.run_cycles, 7);
    tick();
    chk("t4_fail", bus.fail, 1);
    chk("t4_code", bus.fail_code, 3);
    chk("t4_adr", bus.fail_adr, 0);
    tick();
    chk("t4_rc_frozen", bus.run_cycles, 7);
    do_clear();

    // final match on the timeout cycle passes
    load(32'd100, 32'd7);
    go();
    repeat (7) tick();
    wr(32'd100, 32'd7);
    chk("t4b_pass", bus.pass, 1);
    chk("t4b_nofail", bus.fail, 0);
    do_clear();

    // full table, fifth load dropped
    load(32'd0, 32'd1);
    load(32'd4, 32'd2);
    load(32'd8, 32'd3);
    chk("t5_ready_3", bus.load_ready, 1);
    load(32'd12, 32'd4);
    chk("t5_ready_full", bus.load_ready, 0);
    load(32'd16, 32'd5);
    go();
    wr(32'd0, 32'd1);
    wr(32'd4, 32'd2);
    wr(32'd8, 32'd3);
    chk("t5_mc3", bus.match_count, 3);
    chk("t5_pass_early", bus.pass, 0);
    wr(32'd12, 32'd4);
    chk("t5_pass", bus.pass, 1);
    chk("t5_mc4", bus.match_count, 4);
    do_clear();

    // out-of-order
    load(32'd0, 32'd1);
    load(32'd4, 32'd2);
    load(32'd8, 32'd3);
    load(32'd12, 32'd4);
    go();
    wr(32'd4, 32'd2);
    chk("t5b_code", bus.fail_code, 1);
    chk("t5b_adr", bus.fail_adr, 4);
    chk("t5b_data", bus.fail_data, 2);
    do_clear();

    // asynchronous reset mid-run
    load(32'd0, 32'd1);
    load(32'd4, 32'd2);
    load(32'd8, 32'd3);
    go();
    wr(32'd0, 32'd1);
    wr(32'd4, 32'd2);
    chk("t6_mc2", bus.match_count, 2);
    reset = 1'b0;
    #1;
    chk("t6_rst_mc", bus.match_count, 0);
    chk("t6_rst_ready", bus.load_ready, 1);
    chk("t6_rst_rc", bus.run_cycles, 0);
    tick();
    reset = 1'b1;

    // load and start together, then clear from PASS and run a new table
    bus.load_valid = 1'b1; bus.load_adr = 32'd100; bus.load_data = 32'd7; bus.start = 1'b1;
    tick();
    bus.load_valid = 1'b0; bus.start = 1'b0;
    chk("t6_same_cycle_run", bus.load_ready, 0);
    wr(32'd100, 32'd7);
    chk("t6_pass", bus.pass, 1);
    do_clear();
    chk("t6_clr_pass", bus.pass, 0);
    chk("t6_clr_ready", bus.load_ready, 1);
    load(32'd200, 32'd9);
    go();
    wr(32'd200, 32'd9);
    chk("t6_new_pass", bus.pass, 1);
    chk("t6_new_mc", bus.match_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised self-checking monitor for the ARM single-cycle and later cores.
- Watches the data-memory write port (MemWrite, DataAdr, WriteData) and compares writes against a loaded ordered list of expected address/data pairs.
- Tolerates writes to a designated scratch address.
- Reports pass, fail with a cause, or timeout, so a bench or FPGA LED can read a verdict without $display logic.

Parameters:
- ADDR_W, 32, width of DataAdr and stored expected addresses
- DATA_W, 32, width of WriteData and stored expected data
- NUM_CHECKS, 4, depth of the expected-write table (>=1)
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before timeout (>=2)
- IGNORE_EN, 1, 1 = writes to IGNORE_ADR are tolerated in RUN
- IGNORE_ADR, 96, scratch address that is never a mismatch when IGNORE_EN=1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous return to LOAD; empties the table
- load_valid  in  1  expected-entry write strobe
- load_adr  in  ADDR_W  expected address
- load_data  in  DATA_W  expected data
- load_ready  out  1  table accepts an entry this cycle
- start  in  1  begin checking
- MemWrite  in  1  core memory write enable
- DataAdr  in  ADDR_W  core write address
- WriteData  in  DATA_W  core write data
- pass  out  1  sticky success
- fail  out  1  sticky failure
- done  out  1  pass|fail
- fail_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
- fail_adr  out  ADDR_W  DataAdr of the offending write (0 on timeout)
- fail_data  out  DATA_W  WriteData of the offending write (0 on timeout)
- match_count  out  $clog2(NUM_CHECKS+1)  expected entries matched so far
- run_cycles  out  $clog2(TIMEOUT_CYCLES+1)  cycles spent in RUN

Behaviour:
- Reset (reset=0, async):
  - state=LOAD; table count n=0.
  - All outputs 0 except load_ready=1.
  - Table contents need not be cleared.
- States: LOAD, RUN, PASS, FAIL. All inputs are sampled on the rising clk edge.
- LOAD:
  - load_ready = (n < NUM_CHECKS).
  - load_valid & load_ready stores the pair at index n, then n++.
  - load_valid while full is dropped silently.
  - start with n>=1 -> RUN; run_cycles=0, idx=0.
  - start with n=0 is ignored.
  - If start and load_valid arrive in the same cycle, the load completes first and start uses the updated n.
- RUN: load_ready=0. Per cycle, evaluated in this priority order:
  - 1. MemWrite & DataAdr==exp_adr[idx] & WriteData==exp_data[idx]: idx++, match_count++. If idx was n-1 -> PASS.
  - 2. MemWrite & IGNORE_EN & DataAdr==IGNORE_ADR: no effect. A matching expected entry at that address takes priority 1.
  - 3. MemWrite & DataAdr==exp_adr[idx] but data differs: FAIL, fail_code=2, capture fail_adr/fail_data.
  - 4. MemWrite otherwise: FAIL, fail_code=1, capture.
  - 5. No MemWrite: no check.
  - run_cycles increments every RUN cycle.
  - If run_cycles==TIMEOUT_CYCLES-1 and the cycle does not end in PASS or FAIL -> FAIL, fail_code=3.
  - A final match on the timeout cycle yields PASS; a mismatch on the timeout cycle reports codes 1/2, not 3.
- Only the expected entry at idx is compared; out-of-order writes fail with code 1 or 2.
- PASS/FAIL: terminal and sticky. All inputs except clear and reset are ignored; run_cycles freezes.
- Outputs are registered and change one cycle after the deciding edge: pass/fail visible the cycle after the final write is sampled.
- clear (any state) -> LOAD:
  - n=0, match_count=0, run_cycles=0.
  - pass/fail/fail_code/fail_adr/fail_data=0.
  - clear has priority over every other input in the same cycle.
- Reset asserted mid-RUN aborts immediately (async); state and all outputs take reset values.
- Comparisons are full-width equality. X/Z on DataAdr while MemWrite=1 counts as a mismatch.

Test Plan:
- Load (100,7); start; core writes (96,3),(96,5),(100,7) -> pass=1 one cycle later, match_count=1, fail_code=0.
- Load (100,7); write (104,7) -> fail=1, fail_code=1, fail_adr=104, fail_data=7; later writes leave outputs unchanged.
- Load (100,7); write (100,6) -> fail_code=2, fail_data=6; IGNORE_EN=0 build with write (96,1) -> fail_code=1.
- TIMEOUT_CYCLES=8, load (100,7), no writes -> fail_code=3 after 8 RUN cycles, run_cycles=7 frozen; second run with (100,7) on the 8th cycle -> pass.
- NUM_CHECKS=4, load 5 entries -> 5th dropped (load_ready=0). Writes (0,1),(4,2),(8,3),(12,4) -> pass, match_count=4. Swapped order -> fail_code=1.
- Assert reset low mid-RUN with match_count=2 -> all outputs 0, load_ready=1 immediately. clear in PASS -> LOAD, new table loads and runs.
